// File: rtl/vscale_if_stage_pkg.sv
// vscale_if_stage_pkg
//   Shared constants for the instruction-fetch stage: datapath widths,
//   the default reset PC, the canonical NOP encoding and the IF FSM
//   state encoding.
package vscale_if_stage_pkg;

    localparam int XPR_LEN    = 32;
    localparam int INST_WIDTH = 32;

    // Control constants
    localparam logic [XPR_LEN-1:0] RESET_PC_DEFAULT = 32'h0000_0200;

    // RV32 opcodes: addi x0, x0, 0
    localparam logic [INST_WIDTH-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_BOOT    = 2'd0,
        IF_RUN     = 2'd1,
        IF_STALLED = 2'd2
    } if_state_e;

endpackage

// File: rtl/vscale_inst_buffer.sv
// vscale_inst_buffer
//   One-entry holding register for a fetched instruction that DX could
//   not accept in the cycle it arrived.
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     load             capture load_inst/load_fault, mark entry valid
//     clear            discard the entry (consumed or redirected away)
//     load_inst/fault  instruction word and access-fault flag to capture
//     buf_inst/fault   held instruction and fault flag
//     buf_valid        entry holds an instruction
module vscale_inst_buffer
    import vscale_if_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic                  load_fault,
    output logic [INST_WIDTH-1:0] buf_inst,
    output logic                  buf_fault,
    output logic                  buf_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_inst  <= RV_NOP;
            buf_fault <= 1'b0;
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_inst  <= load_inst;
            buf_fault <= load_fault;
            buf_valid <= 1'b1;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vscale_if_stage.sv
// vscale_if_stage
//   Instruction-fetch stage for a pipelined imem with separate address and
//   data phases (at most one request outstanding). Presents fetched
//   instructions to DX with zero latency from the data phase, buffers one
//   instruction when DX stalls, and handles redirects that arrive while
//   the memory is waiting.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     PC_PIF            next PC from the PC mux
//     redirect          control-flow change from DX
//     stall_IF          DX cannot accept inst_IF this cycle
//     imem_wait         imem extends the current address/data phase
//     imem_rdata        instruction returned in the data phase
//     imem_badmem_e     access fault for the completing data phase
//     imem_req/addr     address phase request and fetch address
//     PC_IF             PC of the instruction in IF
//     inst_IF           instruction to DX (NOP when not valid)
//     inst_valid_IF     inst_IF is a real, unkilled instruction
//     fetch_fault_IF    inst_IF carries an imem access fault
//     state_dbg         current FSM state (if_state_e encoding)
//
//   Handshake to DX: inst_valid_IF is the valid and ~stall_IF is the ready.
//   An instruction transfers in a cycle where both are high. When valid is
//   high and ready is low the instruction is held in the buffer and shown
//   again, unchanged, every cycle until ready rises or DX redirects.
module vscale_if_stage
    import vscale_if_stage_pkg::*;
#(
    parameter logic [XPR_LEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XPR_LEN-1:0]    PC_PIF,
    input  logic                  redirect,
    input  logic                  stall_IF,
    input  logic                  imem_wait,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  imem_badmem_e,
    output logic                  imem_req,
    output logic [XPR_LEN-1:0]    imem_addr,
    output logic [XPR_LEN-1:0]    PC_IF,
    output logic [INST_WIDTH-1:0] inst_IF,
    output logic                  inst_valid_IF,
    output logic                  fetch_fault_IF,
    output logic [1:0]            state_dbg
);

    if_state_e             state;
    logic                  dphase;      // data phase outstanding
    logic                  kill;        // outstanding data phase is dead
    logic                  redir_pend;  // address still owed to the bus
    logic [XPR_LEN-1:0]    redir_pc;

    logic                  in_boot;
    logic                  in_run;
    logic                  in_stalled;
    logic                  redirect_eff;
    logic                  dcomplete;
    logic                  accept;
    logic                  present_bus;
    logic                  present_buf;
    logic                  buf_load;
    logic                  buf_clear;

    logic [INST_WIDTH-1:0] buf_inst;
    logic                  buf_fault;
    logic                  buf_valid;

    assign in_boot    = (state == IF_BOOT);
    assign in_run     = (state == IF_RUN);
    assign in_stalled = (state == IF_STALLED);

    // Nothing can be in flight during BOOT, so a redirect there has no
    // meaning; the reset fetch always goes out first.
    assign redirect_eff = redirect & ~in_boot;

    assign dcomplete = dphase & ~imem_wait;

    always_comb begin
        imem_req = ~reset & (in_boot | redir_pend | redirect_eff | ~stall_IF);
        if (in_boot) begin
            imem_addr = RESET_PC;
        end else if (redir_pend) begin
            imem_addr = redir_pc;
        end else begin
            imem_addr = PC_PIF;
        end
    end

    assign accept = imem_req & ~imem_wait;

    // A redirect in the same cycle invalidates whatever IF would show.
    assign present_bus = ~reset & in_run & dcomplete & ~kill & ~redirect_eff;
    assign present_buf = ~reset & in_stalled & buf_valid & ~redirect_eff;

    always_comb begin
        inst_valid_IF  = present_bus | present_buf;
        inst_IF        = RV_NOP;
        fetch_fault_IF = 1'b0;
        if (present_buf) begin
            inst_IF        = buf_inst;
            fetch_fault_IF = buf_fault;
        end else if (present_bus) begin
            inst_IF        = imem_rdata;
            fetch_fault_IF = imem_badmem_e;
        end
    end

    assign buf_load  = present_bus & stall_IF;
    assign buf_clear = in_stalled & (redirect_eff | ~stall_IF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IF_BOOT;
            PC_IF      <= RESET_PC;
            dphase     <= 1'b0;
            kill       <= 1'b0;
            redir_pend <= 1'b0;
            redir_pc   <= RESET_PC;
        end else begin
            // Accepting a new address and finishing the old data phase
            // happen in the same wait-free cycle, keeping one outstanding.
            if (accept) begin
                PC_IF  <= imem_addr;
                dphase <= 1'b1;
            end else if (dcomplete) begin
                dphase <= 1'b0;
            end

            if (dcomplete) begin
                kill <= 1'b0;
            end else if (redirect_eff & imem_wait & dphase) begin
                kill <= 1'b1;
            end

            // An address that could not be issued because of imem_wait is
            // remembered and issued in the first wait-free cycle. A boot
            // fetch stalled by imem_wait is retried the same way, so the
            // unconditional BOOT -> RUN step never loses RESET_PC.
            if (imem_wait) begin
                if (in_boot) begin
                    redir_pend <= 1'b1;
                    redir_pc   <= RESET_PC;
                end else if (redirect_eff) begin
                    redir_pend <= 1'b1;
                    redir_pc   <= PC_PIF;
                end
            end else begin
                redir_pend <= 1'b0;
            end

            case (state)
                IF_BOOT:    state <= IF_RUN;
                IF_RUN:     if (buf_load)  state <= IF_STALLED;
                IF_STALLED: if (buf_clear) state <= IF_RUN;
                default:    state <= IF_BOOT;
            endcase
        end
    end

    vscale_inst_buffer u_inst_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_inst  (imem_rdata),
        .load_fault (imem_badmem_e),
        .buf_inst   (buf_inst),
        .buf_fault  (buf_fault),
        .buf_valid  (buf_valid)
    );

    assign state_dbg = state;

endmodule

// File: tb/tb_vscale_if_stage.sv
// tb_vscale_if_stage
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a transaction-level model of the fetch stage: a queue of
//   outstanding fetch addresses (with a killed flag), a queue holding at
//   most one stalled instruction, and an owed-address register.
module tb_vscale_if_stage;
    import vscale_if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0200;
    localparam logic [31:0] NOP_I  = 32'h0000_0013;

    // Clock / reset block
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] PC_PIF = '0;
    logic        redirect = 1'b0;
    logic        stall_IF = 1'b0;
    logic        imem_wait = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_badmem_e = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC_IF;
    logic [31:0] inst_IF;
    logic        inst_valid_IF;
    logic        fetch_fault_IF;
    logic [1:0]  state_dbg;

    vscale_if_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .PC_PIF         (PC_PIF),
        .redirect       (redirect),
        .stall_IF       (stall_IF),
        .imem_wait      (imem_wait),
        .imem_rdata     (imem_rdata),
        .imem_badmem_e  (imem_badmem_e),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .PC_IF          (PC_IF),
        .inst_IF        (inst_IF),
        .inst_valid_IF  (inst_valid_IF),
        .fetch_fault_IF (fetch_fault_IF),
        .state_dbg      (state_dbg)
    );

    int n_vectors = 0;
    int n_miscompares = 0;

    // Scoreboard / model state
    logic [31:0] exp_q[$];       // addresses accepted, data not yet returned
    bit          kill_q[$];      // parallel to exp_q: fetch is dead
    logic [31:0] held_q[$];      // instruction waiting for DX
    bit          held_fault_q[$];
    bit          m_booting = 1'b1;
    bit          m_retry = 1'b0;
    logic [31:0] m_retry_pc = '0;
    logic [31:0] m_pc = RST_PC;

    // Snapshot of DUT outputs taken in the last step
    logic        obs_req, obs_valid, obs_fault;
    logic [31:0] obs_addr, obs_pc, obs_inst;
    logic [1:0]  obs_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: apply inputs after the falling edge, compare 1ns later,
    // advance the model across the rising edge.
    task automatic step(input bit rst, input logic [31:0] pcp, input bit rd, input bit st,
                        input bit wt, input logic [31:0] rdt, input bit bad);
        bit          done, show_bus, show_held, rd_eff, accepted;
        bit          e_req, e_valid, e_fault;
        logic [31:0] e_addr, e_inst;
        reset = rst; PC_PIF = pcp; redirect = rd; stall_IF = st;
        imem_wait = wt; imem_rdata = rdt; imem_badmem_e = bad;
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_pc = PC_IF; obs_inst = inst_IF;
        obs_valid = inst_valid_IF; obs_fault = fetch_fault_IF; obs_state = state_dbg;

        rd_eff    = rd && !m_booting;
        done      = (exp_q.size() != 0) && !wt;
        show_held = (held_q.size() != 0) && !rd_eff;
        show_bus  = (held_q.size() == 0) && done && !rd_eff;
        if (show_bus) show_bus = !kill_q[0];

        e_req = 1'b0; e_addr = RST_PC; e_valid = 1'b0; e_inst = NOP_I; e_fault = 1'b0;
        if (!rst) begin
            if (m_booting) begin
                e_req = 1'b1; e_addr = RST_PC;
            end else begin
                e_req  = m_retry || rd_eff || !st;
                e_addr = m_retry ? m_retry_pc : pcp;
            end
            e_valid = show_held || show_bus;
            if (show_held) begin
                e_inst = held_q[0]; e_fault = held_fault_q[0];
            end else if (show_bus) begin
                e_inst = rdt; e_fault = bad;
            end
        end
        check("imem_req", {31'd0, obs_req}, {31'd0, e_req});
        check("inst_valid_IF", {31'd0, obs_valid}, {31'd0, e_valid});
        check("inst_IF", obs_inst, e_inst);
        check("fetch_fault_IF", {31'd0, obs_fault}, {31'd0, e_fault});
        if (!rst && e_req) check("imem_addr", obs_addr, e_addr);
        if (!rst) check("PC_IF", obs_pc, m_pc);

        @(posedge clk);
        if (rst) begin
            m_booting = 1'b1; m_retry = 1'b0; m_pc = RST_PC;
            exp_q.delete(); kill_q.delete(); held_q.delete(); held_fault_q.delete();
        end else begin
            accepted = e_req && !wt;
            if (done) begin
                void'(exp_q.pop_front());
                void'(kill_q.pop_front());
            end
            if (m_booting && wt) begin
                m_retry = 1'b1; m_retry_pc = RST_PC;
            end else if (rd_eff && wt) begin
                m_retry = 1'b1; m_retry_pc = pcp;
                if (kill_q.size() != 0) kill_q[0] = 1'b1;
            end else if (!wt) begin
                m_retry = 1'b0;
            end
            if (accepted) begin
                exp_q.push_back(e_addr); kill_q.push_back(1'b0); m_pc = e_addr;
            end
            if (held_q.size() != 0) begin
                if (rd_eff || !st) begin
                    held_q.delete(); held_fault_q.delete();
                end
            end else if (show_bus && st) begin
                held_q.push_back(rdt); held_fault_q.push_back(bad);
            end
            m_booting = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset
        step(1, 32'h200, 0, 0, 0, 32'h0, 0);
        step(1, 32'h200, 0, 0, 1, 32'h0, 1);
        check("rst_req", {31'd0, obs_req}, 32'd0);
        check("rst_inst", obs_inst, NOP_I);

        // Boot fetch and first instruction
        step(0, 32'h204, 0, 0, 0, 32'h0010_0093, 0);
        check("boot_addr", obs_addr, 32'h200);
        check("boot_state", {30'd0, obs_state}, {30'd0, IF_BOOT});
        step(0, 32'h204, 0, 0, 0, 32'h0010_0093, 0);
        check("first_pc", obs_pc, 32'h200);
        check("first_inst", obs_inst, 32'h0010_0093);
        check("first_valid", {31'd0, obs_valid}, 32'd1);

        // Three wait cycles on the 0x204 data phase
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h208, 0, 0, 1, 32'hDEAD_0013, 0);
            check("wait_pc", obs_pc, 32'h204);
            check("wait_valid", {31'd0, obs_valid}, 32'd0);
        end
        step(0, 32'h208, 0, 0, 0, 32'h0020_0113, 0);
        check("wait_done_valid", {31'd0, obs_valid}, 32'd1);

        // Stall as 0x208 completes, then release
        step(0, 32'h20C, 0, 1, 0, 32'hABCD_0013, 0);
        check("stall_inst", obs_inst, 32'hABCD_0013);
        check("stall_req", {31'd0, obs_req}, 32'd0);
        step(0, 32'h20C, 0, 1, 0, 32'h1111_0013, 0);
        check("stalled_inst", obs_inst, 32'hABCD_0013);
        check("stalled_state", {30'd0, obs_state}, {30'd0, IF_STALLED});
        step(0, 32'h20C, 0, 0, 0, 32'h2222_0013, 0);
        check("unstall_addr", obs_addr, 32'h20C);
        check("unstall_inst", obs_inst, 32'hABCD_0013);

        // Redirect to 0x400 while the memory waits for two cycles
        step(0, 32'h400, 1, 0, 1, 32'h3333_0013, 0);
        check("redir_valid", {31'd0, obs_valid}, 32'd0);
        step(0, 32'h404, 0, 0, 1, 32'h3333_0013, 0);
        check("redir_hold_valid", {31'd0, obs_valid}, 32'd0);
        step(0, 32'h404, 0, 0, 0, 32'h4444_0013, 0);
        check("redir_addr", obs_addr, 32'h400);
        check("redir_killed", {31'd0, obs_valid}, 32'd0);

        // Access fault on the redirected fetch
        step(0, 32'h404, 0, 0, 0, 32'h5555_0013, 1);
        check("redir_pc", obs_pc, 32'h400);
        check("fault_flag", {31'd0, obs_fault}, 32'd1);
        check("fault_valid", {31'd0, obs_valid}, 32'd1);

        // Reset in the middle of a wait
        step(0, 32'h408, 0, 0, 1, 32'h0, 0);
        step(1, 32'h408, 0, 0, 1, 32'h0, 0);
        step(0, 32'h408, 0, 0, 0, 32'h6666_0013, 0);
        check("reboot_addr", obs_addr, 32'h200);
        check("reboot_req", {31'd0, obs_req}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 30,
                 $urandom(),
                 $urandom_range(0, 99) < 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
